// File: rtl/mult_pkg.sv
// Shared types and widths for the shift-free add-loop multiplier controller.
// MULT_CTRL_ZERO_SKIP_EN adds the ZERO state used to short-cut zero operands.
package mult_pkg;

  localparam int OP_W  = 4;
  localparam int RES_W = 8;

`ifdef MULT_CTRL_ZERO_SKIP_EN
  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_LOAD_P = 3'd1,
    ST_LOAD_Q = 3'd2,
    ST_ADD    = 3'd3,
    ST_DONE   = 3'd4,
    ST_ZERO   = 3'd5
  } state_e;
`else
  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_LOAD_P = 3'd1,
    ST_LOAD_Q = 3'd2,
    ST_ADD    = 3'd3,
    ST_DONE   = 3'd4
  } state_e;
`endif

endpackage

// File: rtl/mult_ctrl_if.sv
// Operand/product handshake bundle between the controller and its producer/consumer.
// Signal suffixes are from the controller's point of view.
interface mult_ctrl_if;
  import mult_pkg::*;

  logic             in_valid_i;
  logic             in_ready_o;
  logic [OP_W-1:0]  in_a_i;
  logic [OP_W-1:0]  in_b_i;
  logic             out_valid_o;
  logic             out_ready_i;
  logic [RES_W-1:0] out_data_o;

  modport slave (
    input  in_valid_i, in_a_i, in_b_i, out_ready_i,
    output in_ready_o, out_valid_o, out_data_o
  );

  modport master (
    output in_valid_i, in_a_i, in_b_i, out_ready_i,
    input  in_ready_o, out_valid_o, out_data_o
  );

endinterface

// File: rtl/mult_ctrl.sv
// Sequencer for a repeated-addition multiplier datapath (P, Q down-counter, F accumulator).
// MULT_CTRL_ZERO_SKIP_EN enables the ZERO state that bypasses the add loop for zero operands.
//
// state   | meaning
// IDLE    | waiting for an operand pair, in_ready_o high
// LOAD_P  | drive a onto the datapath bus, load P, clear F
// LOAD_Q  | drive b onto the datapath bus, load Q
// ADD     | F += P and Q -= 1 until Q reaches zero, then capture F
// DONE    | product valid, held until the consumer takes it
// ZERO    | (optional) clear F, product forced to 0
module mult_ctrl
  import mult_pkg::*;
(
  input  logic             clk_i,
  input  logic             rst_i,
  mult_ctrl_if.slave       bus,
  output logic [OP_W-1:0]  dp_data_o,
  output logic             load_p_o,
  output logic             load_q_o,
  output logic             load_f_o,
  output logic             clr_f_o,
  output logic             dec_q_o,
  input  logic             zero_i,
  input  logic [RES_W-1:0] dp_result_i
);

  state_e           state_q, state_d;
  logic [OP_W-1:0]  a_q, a_d;
  logic [OP_W-1:0]  b_q, b_d;
  logic [RES_W-1:0] res_q, res_d;

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      state_q <= ST_IDLE;
      a_q     <= '0;
      b_q     <= '0;
      res_q   <= '0;
    end else begin
      state_q <= state_d;
      a_q     <= a_d;
      b_q     <= b_d;
      res_q   <= res_d;
    end
  end

  always_comb begin
    state_d         = state_q;
    a_d             = a_q;
    b_d             = b_q;
    res_d           = res_q;
    bus.in_ready_o  = 1'b0;
    bus.out_valid_o = 1'b0;
    dp_data_o       = '0;
    load_p_o        = 1'b0;
    load_q_o        = 1'b0;
    load_f_o        = 1'b0;
    clr_f_o         = 1'b0;
    dec_q_o         = 1'b0;

    case (state_q)
      ST_IDLE: begin
        bus.in_ready_o = 1'b1;
        if (bus.in_valid_i) begin
          a_d = bus.in_a_i;
          b_d = bus.in_b_i;
`ifdef MULT_CTRL_ZERO_SKIP_EN
          if (bus.in_a_i == '0 || bus.in_b_i == '0) state_d = ST_ZERO;
          else                                      state_d = ST_LOAD_P;
`else
          state_d = ST_LOAD_P;
`endif
        end
      end
      ST_LOAD_P: begin
        dp_data_o = a_q;
        load_p_o  = 1'b1;
        clr_f_o   = 1'b1;
        state_d   = ST_LOAD_Q;
      end
      ST_LOAD_Q: begin
        dp_data_o = b_q;
        load_q_o  = 1'b1;
        state_d   = ST_ADD;
      end
      ST_ADD: begin
        // Q already holds the remaining add count; zero_i ends the loop.
        if (!zero_i) begin
          load_f_o = 1'b1;
          dec_q_o  = 1'b1;
        end else begin
          res_d   = dp_result_i;
          state_d = ST_DONE;
        end
      end
      ST_DONE: begin
        bus.out_valid_o = 1'b1;
        if (bus.out_ready_i) state_d = ST_IDLE;
      end
`ifdef MULT_CTRL_ZERO_SKIP_EN
      ST_ZERO: begin
        clr_f_o = 1'b1;
        res_d   = '0;
        state_d = ST_DONE;
      end
`endif
      default: state_d = ST_IDLE;
    endcase
  end

  assign bus.out_data_o = res_q;

endmodule

// File: doc/mult_ctrl.md
MULT_CTRL -- requirements
Module: mult_ctrl

Interface
REQ-001 SHALL have port clk_i, input, 1, the single clock; all state changes on its rising edge.
REQ-002 SHALL have port rst_i, input, 1, asynchronous active-low reset.
REQ-003 SHALL have port in_valid_i, input, 1, operand pair valid.
REQ-004 SHALL have port in_ready_o, output, 1, controller can accept an operand pair.
REQ-005 SHALL have port in_a_i, input, 4, multiplicand, loaded into datapath register P.
REQ-006 SHALL have port in_b_i, input, 4, multiplier, loaded into datapath counter Q.
REQ-007 SHALL have port out_valid_o, output, 1, product valid.
REQ-008 SHALL have port out_ready_i, input, 1, consumer accepts the product.
REQ-009 SHALL have port out_data_o, output, 8, product.
REQ-010 SHALL have port dp_data_o, output, 4, operand bus to the datapath data input.
REQ-011 SHALL have ports load_p_o, load_q_o, load_f_o, clr_f_o and dec_q_o, output, 1 each, datapath controls.
REQ-012 SHALL have port zero_i, input, 1, datapath counter Q equals zero (combinational).
REQ-013 SHALL have port dp_result_i, input, 8, datapath register F.

Function
REQ-014 SHALL implement states IDLE, LOAD_P, LOAD_Q, ADD, DONE, plus ZERO when REQ-029 applies.
REQ-015 SHALL drive in_ready_o high only in IDLE.
REQ-016 SHALL capture in_a_i and in_b_i into internal operand registers and move IDLE->LOAD_P on in_valid_i && in_ready_o.
REQ-017 SHALL ignore in_valid_i outside IDLE, with no capture and no state change.
REQ-018 In LOAD_P, SHALL drive dp_data_o=a, load_p_o=1 and clr_f_o=1, then go to LOAD_Q.
REQ-019 In LOAD_Q, SHALL drive dp_data_o=b and load_q_o=1, then go to ADD.
REQ-020 In ADD with zero_i=0, SHALL assert load_f_o=1 and dec_q_o=1 in the same cycle and stay in ADD.
REQ-021 In ADD with zero_i=1, SHALL assert no datapath control, capture dp_result_i into out_data_o, and go to DONE.
REQ-022 SHALL assert out_valid_o in DONE, holding out_data_o stable until out_valid_o && out_ready_i, then go to IDLE.
REQ-023 SHALL place the handshake edge at cycle 0, giving out_valid_o high at cycle b+4 for b=0..15, with no a dependence on the normal path.
REQ-024 SHALL keep out_data_o modulo 256 (max 15*15=225, so no overflow occurs).
REQ-025 SHALL drive dp_data_o=0 and all datapath controls 0 in IDLE and DONE.
REQ-026 SHALL tolerate out_ready_i high before DONE, with no effect.
REQ-027 SHALL take 1 idle cycle between out_valid_o/out_ready_i and the next in_ready_o, giving no back-to-back overlap.

Reset
REQ-028 With rst_i low, at any time and in any state, SHALL immediately force state=IDLE and out_valid_o=0, out_data_o=0, dp_data_o=0, all datapath controls 0, operand registers 0, with in_ready_o=1 after release; a reset mid-ADD SHALL abandon the operation with no partial product output.

Configuration
REQ-029 With MULT_CTRL_ZERO_SKIP_EN defined, SHALL go IDLE->ZERO on acceptance when a==0 or b==0; ZERO SHALL assert clr_f_o=1 for one cycle and then go to DONE with out_data_o=0, giving out_valid_o at cycle 2.
REQ-030 Without MULT_CTRL_ZERO_SKIP_EN, SHALL exclude the ZERO state from compilation and send all operands through the REQ-018..023 path.

Structure
REQ-031 SHALL take from shared package mult_pkg: state enum type, OP_W=4, RES_W=8.
REQ-032 SHALL be a single module with no sub-module; the state register, operand registers and result register SHALL be local.

Verification
REQ-033 SHALL cover: a=3, b=5 with out_ready_i=1 -> out_data_o=15, out_valid_o at cycle 9, load_f_o pulsed 5 times.
REQ-034 SHALL cover: a=15, b=15 -> out_data_o=225 at cycle 19.
REQ-035 SHALL cover: a=7, b=0 without the macro -> out_data_o=0 at cycle 4, load_f_o never asserted; with the macro, a=0, b=9 -> out_data_o=0 at cycle 2.
REQ-036 SHALL cover: a=4, b=2 with out_ready_i held low 5 cycles -> out_valid_o and 8 held stable for 5 cycles, and in_valid_i with a new pair during that time ignored.
REQ-037 SHALL cover: rst_i low for 1 cycle during ADD of a=6, b=10 -> all outputs at reset values, then a new a=2, b=3 -> 6 at cycle 7.
